vppm_tx_core: RTL
=================

Name: vppm_tx_core

Overview:
- Single-clock, parametrised next-generation VLC transmit core: synchronous word FIFO, MSB-first serializer and VPPM modulator with dimming control, all in the pclk domain.
- Sits between the host write interface and the LED driver pin.
- Unlike the previous generation, it adds:
  - parametrised word width, FIFO depth and slot length
  - fill-level reporting
  - flicker-free idle (dimming pulses continue with no data)
  - gapless back-to-back frames
  - optional preamble insertion

Parameters:
DATA_W, 32, serialized word width in bits (>=2).
DEPTH, 16, FIFO depth in words (power of 2, >=2).
SLOT_CYCLES, 16, pclk cycles per VPPM bit slot (power of 2, >=4).
DIM_W, 4, dim input width, equals log2(SLOT_CYCLES).

Ports:
pclk  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
wr_data  in  DATA_W  word to enqueue.
wr_en  in  1  write request, sampled on the pclk rising edge.
fifo_full  out  1  FIFO holds DEPTH words.
fifo_wr_success  out  1  one-cycle pulse, the write in the previous cycle was accepted.
fifo_level  out  log2(DEPTH)+1  words currently stored.
dim  in  DIM_W  requested pulse width in pclk cycles.
tx_out  out  1  VPPM waveform to the LED driver.
busy  out  1  high while in PREAMBLE or DATA.

Behaviour:
- Reset:
  - Asynchronous; all state clears immediately, including mid-frame. Any in-flight word and all FIFO contents are discarded.
  - Values while and after reset: tx_out=0, busy=0, fifo_full=0, fifo_wr_success=0, fifo_level=0, state=IDLE, slot_cnt=0, bit_cnt=0.
- FIFO write:
  - wr_en=1 and fifo_full=0 at an edge: the word is stored and fifo_wr_success=1 in the next cycle.
  - wr_en=1 and fifo_full=1: the write is dropped, fifo_wr_success=0. This holds even if a pop happens in the same cycle.
  - Simultaneous push and pop: fifo_level is unchanged.
  - fifo_full and fifo_level are registered and reflect the post-edge contents. Pointers wrap modulo DEPTH.
- Slot timing:
  - slot_cnt runs free from 0 to SLOT_CYCLES-1 and wraps, in every state.
  - The slot boundary is slot_cnt==SLOT_CYCLES-1.
  - At each boundary: the state and current bit update, and dim is latched into W = clamp(dim, 1, SLOT_CYCLES-1). dim=0 gives W=1.
  - dim changes mid-slot have no effect until the next boundary.
- Modulation:
  - tx_out is a register. During the cycle in which slot_cnt=k (current bit b), tx_out shows the value computed from k-1, so the output lags the counter by exactly 1 cycle.
  - Bit 0: tx_out=1 for k<W, 0 otherwise.
  - Bit 1: tx_out=1 for k>=SLOT_CYCLES-W, 0 otherwise.
  - Average duty is W/SLOT_CYCLES, independent of the data.
- State machine (transitions only at slot boundaries):
  - IDLE:
    - Emits bit-0 pattern slots, so the dim level is maintained. busy=0.
    - If FIFO is not empty: pop one word into the shift register. With the macro, go to PREAMBLE; without it, go to DATA.
  - PREAMBLE (macro only): sends 8 bits, then goes to DATA.
  - DATA:
    - Sends DATA_W bits MSB first. bit_cnt counts 0..DATA_W-1.
    - At the boundary ending the last bit:
      - FIFO not empty: pop and stay in DATA with bit_cnt=0. No gap and no preamble between words.
      - FIFO empty: go to IDLE.
- Latency:
  - A write into an empty, idle core is popped at the first slot boundary at least 1 cycle after fifo_level becomes 1.
  - The first modulated bit appears on tx_out 1 cycle after that boundary.
- Pop never occurs when the FIFO is empty, so there is no underflow. Reads of the shift register happen only at boundaries.

Optional Feature:
- Macro VLC_PREAMBLE_EN.
- Defined:
  - Every IDLE->busy transition inserts an 8-bit preamble, pattern 8'hA5, MSB first, before the data word.
  - busy is high during the preamble.
  - Back-to-back words within a frame carry no preamble.
- Undefined: the PREAMBLE state and pattern logic are absent, and IDLE goes straight to DATA.

Test Plan:
- Reset then idle, dim=4, SLOT_CYCLES=16, no writes -> tx_out high exactly 4 of every 16 cycles, in slot positions 0-3 (bit-0 pattern); busy=0; fifo_level=0.
- Write 32'h8000_0001, dim=4, macro off -> fifo_wr_success pulses 1 cycle later. At the next boundary: busy=1, level 1->0. The first slot carries bit 1 (high in positions 12-15), then 30 slots of bit 0, then a final bit 1. busy falls at the end of the 32nd slot.
- Fill 16 words then write a 17th -> fifo_full=1, fifo_level=16, no fifo_wr_success pulse for the 17th. All 16 words are transmitted with no idle slot between them, and level reaches 0.
- dim=0 and dim=15 -> W=1 and W=15 respectively. Changing dim from 4 to 8 mid-slot takes effect only at the next slot boundary.
- Assert reset while bit 10 of a word is on air with 3 words queued -> tx_out=0 and fifo_level=0 immediately. After release: IDLE pattern, and no queued data is sent.
- VLC_PREAMBLE_EN defined, write two words -> slots show 1,0,1,0,0,1,0,1 followed by 64 data slots, with exactly one preamble for the pair.

Source files
------------

// File: rtl/vppm_tx_core.sv
// vppm_tx_core
// Single-clock VLC transmit core: synchronous word FIFO, MSB-first serializer
// and VPPM modulator with dimming control.
//
// Optional feature macro: VLC_PREAMBLE_EN
//   When defined, every transition from idle to transmitting inserts an 8-bit
//   preamble (8'hA5, MSB first) ahead of the first data word of a frame.
//
// Ports:
//   pclk             system clock, all logic on the rising edge
//   reset            asynchronous, active-high reset
//   wr_data          word to enqueue
//   wr_en            write request
//   fifo_full        FIFO holds DEPTH words
//   fifo_wr_success  one-cycle pulse: write in the previous cycle was accepted
//   fifo_level       words currently stored
//   dim              requested pulse width in pclk cycles (clamped to 1..SLOT_CYCLES-1)
//   tx_out           VPPM waveform to the LED driver
//   busy             high while a preamble or data word is on air
`timescale 1ns/1ps

module vppm_tx_core #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int SLOT_CYCLES = 16,
    parameter int DIM_W       = 4
) (
    input  logic                     pclk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_en,
    output logic                     fifo_full,
    output logic                     fifo_wr_success,
    output logic [$clog2(DEPTH):0]   fifo_level,
    input  logic [DIM_W-1:0]         dim,
    output logic                     tx_out,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    // bit counter also walks the 8 preamble bits
    localparam int BC_W  = ($clog2(DATA_W) > 3) ? $clog2(DATA_W) : 3;

    localparam logic [DIM_W-1:0] SLOT_LAST = DIM_W'(SLOT_CYCLES - 1);
    localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_W - 1);

`ifdef VLC_PREAMBLE_EN
    localparam logic [7:0]       PREAMBLE_PAT = 8'hA5;
    localparam logic [BC_W-1:0]  PRE_LAST     = BC_W'(7);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DATA     = 2'd1,
        S_PREAMBLE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DATA     = 2'd1
    } state_t;
`endif

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              full_q;
    logic              full_d;
    logic              wr_ok_q;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    // ------------------------------------------------------------------
    // Slot timing, serializer, modulator
    // ------------------------------------------------------------------
    logic [DIM_W-1:0]  slot_cnt_q;
    logic [DIM_W-1:0]  w_q;
    logic [DIM_W-1:0]  w_d;
    logic [DIM_W-1:0]  hi_start;
    logic              boundary;
    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic              last_bit;
    logic              cur_bit;
    logic              busy_q;
    logic              tx_q;
`ifdef VLC_PREAMBLE_EN
    logic [7:0]        pre_q;
`endif

    always_comb begin
        boundary   = (slot_cnt_q == SLOT_LAST);
        fifo_empty = (level_q == '0);
        last_bit   = (bit_cnt_q == DATA_LAST);

        // pop only where the state machine loads the shift register
        pop  = boundary && !fifo_empty &&
               ((state_q == S_IDLE) || ((state_q == S_DATA) && last_bit));
        // a full FIFO refuses writes even if a pop frees a slot this cycle
        push = wr_en && !full_q;

        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        full_d  = (level_d == LVL_W'(DEPTH));

        w_d = (dim == '0) ? DIM_W'(1) : dim;

        // SLOT_CYCLES - W computed modulo SLOT_CYCLES; W >= 1 keeps it in range
        hi_start = '0 - w_q;

        cur_bit = 1'b0;
        case (state_q)
            S_DATA:     cur_bit = shreg_q[DATA_W-1];
`ifdef VLC_PREAMBLE_EN
            S_PREAMBLE: cur_bit = pre_q[7];
`endif
            default:    cur_bit = 1'b0;
        endcase
    end

    // FIFO storage carries no reset; pointers and level define its contents
    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            wr_ok_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
            full_q  <= full_d;
            wr_ok_q <= push;
        end
    end

    // State machine, slot counter and modulator; all outputs registered
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
            slot_cnt_q <= '0;
            w_q        <= DIM_W'(1);
            tx_q       <= 1'b0;
`ifdef VLC_PREAMBLE_EN
            pre_q      <= '0;
`endif
        end else begin
            slot_cnt_q <= slot_cnt_q + DIM_W'(1);

            // output lags the slot counter by one cycle
            tx_q <= cur_bit ? (slot_cnt_q >= hi_start) : (slot_cnt_q < w_q);

            if (boundary) begin
                w_q <= w_d;
                case (state_q)
                    S_IDLE: begin
                        if (!fifo_empty) begin
                            shreg_q   <= mem_q[rd_ptr_q];
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b1;
`ifdef VLC_PREAMBLE_EN
                            pre_q     <= PREAMBLE_PAT;
                            state_q   <= S_PREAMBLE;
`else
                            state_q   <= S_DATA;
`endif
                        end
                    end
`ifdef VLC_PREAMBLE_EN
                    S_PREAMBLE: begin
                        if (bit_cnt_q == PRE_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= S_DATA;
                        end else begin
                            pre_q     <= {pre_q[6:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                        end
                    end
`endif
                    S_DATA: begin
                        if (last_bit) begin
                            if (!fifo_empty) begin
                                // next word follows with no gap and no preamble
                                shreg_q   <= mem_q[rd_ptr_q];
                                bit_cnt_q <= '0;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fifo_full       = full_q;
    assign fifo_wr_success = wr_ok_q;
    assign fifo_level      = level_q;
    assign tx_out          = tx_q;
    assign busy            = busy_q;

endmodule
